// File: rtl/dmi_pkg.sv
// rtl/dmi_pkg.sv - shared state encoding and byteenable constants for the data-memory master
package dmi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } dmi_state_t;

    localparam logic [3:0] ONE_BYTE   = 4'b0001;
    localparam logic [3:0] TWO_BYTES  = 4'b0011;
    localparam logic [3:0] FOUR_BYTES = 4'b1111;

endpackage

// File: rtl/data_mem_interface_if.sv
// rtl/data_mem_interface_if.sv - core-side and Avalon-side signals of the data-memory master
interface data_mem_interface_if #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 32
);
    logic                 DMI_Req_In;
    logic                 DMI_Store_In;
    logic [ADDRWIDTH-1:0] DMI_Address_InBUS;
    logic [DATAWIDTH-1:0] DMI_WriteData_InBUS;
    logic [3:0]           DMI_Byteenable_InBUS;
    logic                 DMI_Stall_Out;
    logic                 DMI_Done_Out;
    logic                 DMI_Misaligned_Out;
    logic [DATAWIDTH-1:0] DMI_ReadData_OutBUS;
    logic [ADDRWIDTH-1:0] DMI_AvmAddress_OutBUS;
    logic                 DMI_AvmRead_Out;
    logic                 DMI_AvmWrite_Out;
    logic [3:0]           DMI_AvmByteenable_OutBUS;
    logic [DATAWIDTH-1:0] DMI_AvmWriteData_OutBUS;
    logic [DATAWIDTH-1:0] DMI_AvmReadData_InBUS;
    logic                 DMI_AvmWaitrequest_In;
    logic                 DMI_AvmReaddatavalid_In;

    modport master (
        input  DMI_Req_In, DMI_Store_In, DMI_Address_InBUS, DMI_WriteData_InBUS,
               DMI_Byteenable_InBUS, DMI_AvmReadData_InBUS, DMI_AvmWaitrequest_In,
               DMI_AvmReaddatavalid_In,
        output DMI_Stall_Out, DMI_Done_Out, DMI_Misaligned_Out, DMI_ReadData_OutBUS,
               DMI_AvmAddress_OutBUS, DMI_AvmRead_Out, DMI_AvmWrite_Out,
               DMI_AvmByteenable_OutBUS, DMI_AvmWriteData_OutBUS
    );

    modport slave (
        output DMI_Req_In, DMI_Store_In, DMI_Address_InBUS, DMI_WriteData_InBUS,
               DMI_Byteenable_InBUS, DMI_AvmReadData_InBUS, DMI_AvmWaitrequest_In,
               DMI_AvmReaddatavalid_In,
        input  DMI_Stall_Out, DMI_Done_Out, DMI_Misaligned_Out, DMI_ReadData_OutBUS,
               DMI_AvmAddress_OutBUS, DMI_AvmRead_Out, DMI_AvmWrite_Out,
               DMI_AvmByteenable_OutBUS, DMI_AvmWriteData_OutBUS
    );
endinterface

// File: rtl/dmi_lane_align.sv
// rtl/dmi_lane_align.sv - byte-lane steering and alignment check for one access
module dmi_lane_align
    import dmi_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic [1:0]           addr_off,
    input  logic [3:0]           be,
    input  logic [DATAWIDTH-1:0] wdata,
    input  logic [1:0]           rd_off,
    input  logic [DATAWIDTH-1:0] rdata,
    output logic [3:0]           be_lane,
    output logic [DATAWIDTH-1:0] wdata_lane,
    output logic [DATAWIDTH-1:0] rdata_just,
    output logic                 misaligned
);

    always_comb begin
        be_lane    = be << addr_off;
        wdata_lane = wdata << {addr_off, 3'b000};
        // upper bytes are left unmasked; the load/store unit extends from the low end
        rdata_just = rdata >> {rd_off, 3'b000};
        misaligned = ((be == TWO_BYTES) && addr_off[0]) ||
                     ((be == FOUR_BYTES) && (addr_off != 2'b00));
    end

endmodule

// File: rtl/data_mem_interface.sv
// rtl/data_mem_interface.sv - Avalon-MM data-memory master between load/store unit and interconnect
module data_mem_interface
    import dmi_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 32
) (
    input  logic                 DMI_CLOCK_50,
    input  logic                 DMI_RESET_InHigh,
    data_mem_interface_if.master bus
);

    dmi_state_t           state, state_next;
    logic [ADDRWIDTH-1:0] addr_q;
    logic [1:0]           off_q;
    logic                 store_q;
    logic [3:0]           be_q;
    logic [DATAWIDTH-1:0] wdata_q;
    logic [DATAWIDTH-1:0] rdata_q;
    logic                 mis_q;
    logic                 capture;

    logic [3:0]           be_lane;
    logic [DATAWIDTH-1:0] wdata_lane;
    logic [DATAWIDTH-1:0] rdata_just;
    logic                 misaligned;

    dmi_lane_align #(.DATAWIDTH(DATAWIDTH)) u_align (
        .addr_off   (bus.DMI_Address_InBUS[1:0]),
        .be         (bus.DMI_Byteenable_InBUS),
        .wdata      (bus.DMI_WriteData_InBUS),
        .rd_off     (off_q),
        .rdata      (bus.DMI_AvmReadData_InBUS),
        .be_lane    (be_lane),
        .wdata_lane (wdata_lane),
        .rdata_just (rdata_just),
        .misaligned (misaligned)
    );

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.DMI_Req_In) begin
                    state_next = misaligned ? DONE : CMD;
                end
            end
            CMD: begin
                if (!bus.DMI_AvmWaitrequest_In) begin
                    if (store_q) begin
                        state_next = DONE;
                    end else if (bus.DMI_AvmReaddatavalid_In) begin
                        // slave answered in the accept cycle itself
                        capture    = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            RESP: begin
                if (bus.DMI_AvmReaddatavalid_In) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge DMI_CLOCK_50) begin
        if (DMI_RESET_InHigh) begin
            state   <= IDLE;
            addr_q  <= '0;
            off_q   <= 2'b00;
            store_q <= 1'b0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && bus.DMI_Req_In) begin
                mis_q <= misaligned;
                if (!misaligned) begin
                    addr_q  <= {bus.DMI_Address_InBUS[ADDRWIDTH-1:2], 2'b00};
                    off_q   <= bus.DMI_Address_InBUS[1:0];
                    store_q <= bus.DMI_Store_In;
                    be_q    <= be_lane;
                    wdata_q <= wdata_lane;
                end
            end
            if (capture) begin
                rdata_q <= rdata_just;
            end
        end
    end

    assign bus.DMI_AvmRead_Out          = (state == CMD) && !store_q;
    assign bus.DMI_AvmWrite_Out         = (state == CMD) && store_q;
    assign bus.DMI_AvmAddress_OutBUS    = addr_q;
    assign bus.DMI_AvmByteenable_OutBUS = be_q;
    assign bus.DMI_AvmWriteData_OutBUS  = wdata_q;
    assign bus.DMI_Done_Out             = (state == DONE);
    assign bus.DMI_Misaligned_Out       = (state == DONE) && mis_q;
    assign bus.DMI_ReadData_OutBUS      = rdata_q;
    assign bus.DMI_Stall_Out            = ((state == IDLE) && bus.DMI_Req_In) ||
                                          (state == CMD) || (state == RESP);

endmodule

// File: tb/tb_data_mem_interface.sv
// tb/tb_data_mem_interface.sv - self-checking bench for data_mem_interface
module tb_data_mem_interface;
    import dmi_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_interface_if #(.DATAWIDTH(32), .ADDRWIDTH(32)) dmi ();

    data_mem_interface #(.DATAWIDTH(32), .ADDRWIDTH(32)) dut (
        .DMI_CLOCK_50     (clk),
        .DMI_RESET_InHigh (rst),
        .bus              (dmi)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // current transaction as seen by the model
    logic [31:0] t_addr  = 32'h0;
    logic        t_store = 1'b0;
    logic [3:0]  t_be    = 4'h0;
    logic [31:0] t_wd    = 32'h0;
    logic [31:0] t_rword = 32'h0;
    int          t_wait  = 0;
    int          t_delay = 0;
    logic        t_active = 1'b0;
    int          txn_id   = 0;

    function automatic logic exp_mis(input logic [31:0] a, input logic [3:0] be);
        return (be == 4'b0011 && a[0]) || (be == 4'b1111 && a[1:0] != 2'b00);
    endfunction

    function automatic int exp_lat(input logic [31:0] a, input logic st, input logic [3:0] be,
                                   input int w, input int d);
        if (exp_mis(a, be)) return 1;
        if (st) return 2 + w;
        return 2 + w + d;
    endfunction

    // Avalon slave: t_wait waitrequest cycles, readdatavalid t_delay cycles after accept
    int w_cnt   = 0;
    int rd_left = 0;
    always @(posedge clk) begin
        #1;
        dmi.DMI_AvmReaddatavalid_In = 1'b0;
        dmi.DMI_AvmReadData_InBUS   = 32'hBAD0BAD0;
        if (rd_left > 0) begin
            rd_left--;
            if (rd_left == 0) begin
                dmi.DMI_AvmReaddatavalid_In = 1'b1;
                dmi.DMI_AvmReadData_InBUS   = t_rword;
            end
        end
        if (dmi.DMI_AvmRead_Out === 1'b1 || dmi.DMI_AvmWrite_Out === 1'b1) begin
            if (w_cnt < t_wait) begin
                dmi.DMI_AvmWaitrequest_In = 1'b1;
                w_cnt++;
            end else begin
                dmi.DMI_AvmWaitrequest_In = 1'b0;
                w_cnt = 0;
                if (dmi.DMI_AvmRead_Out === 1'b1) begin
                    if (t_delay == 0) begin
                        dmi.DMI_AvmReaddatavalid_In = 1'b1;
                        dmi.DMI_AvmReadData_InBUS   = t_rword;
                    end else begin
                        rd_left = t_delay;
                    end
                end
            end
        end else begin
            dmi.DMI_AvmWaitrequest_In = 1'b0;
            w_cnt = 0;
        end
    end

    // compare process: per-cycle expectations from the access rules
    int          cyc     = 0;
    int          seen_id = 0;
    logic [31:0] last_rd = 32'h0;
    int          strb_cnt = 0;
    logic [31:0] cap_addr = 32'h0;
    logic [3:0]  cap_be   = 4'h0;
    logic [31:0] cap_wd   = 32'h0;
    logic        done_mis = 1'b0;

    always @(negedge clk) begin : cmp
        logic        m;
        logic        ed;
        logic        ic;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        if (rst) begin
            last_rd = 32'h0;
        end else begin
            if (txn_id != seen_id) begin
                seen_id  = txn_id;
                cyc      = 0;
                strb_cnt = 0;
            end
            m    = exp_mis(t_addr, t_be);
            ed   = t_active && (cyc == exp_lat(t_addr, t_store, t_be, t_wait, t_delay));
            ic   = t_active && !m && cyc >= 1 && cyc <= 1 + t_wait;
            e_be = 4'(t_be << t_addr[1:0]);
            e_wd = t_wd << (8 * t_addr[1:0]);
            chk("done", 32'(dmi.DMI_Done_Out), 32'(ed));
            chk("stall", 32'(dmi.DMI_Stall_Out), 32'(t_active && !ed));
            chk("avm_read", 32'(dmi.DMI_AvmRead_Out), 32'(ic && !t_store));
            chk("avm_write", 32'(dmi.DMI_AvmWrite_Out), 32'(ic && t_store));
            if (dmi.DMI_AvmRead_Out === 1'b1 || dmi.DMI_AvmWrite_Out === 1'b1) begin
                strb_cnt++;
                cap_addr = dmi.DMI_AvmAddress_OutBUS;
                cap_be   = dmi.DMI_AvmByteenable_OutBUS;
                cap_wd   = dmi.DMI_AvmWriteData_OutBUS;
            end
            if (ic) begin
                chk("avm_address", dmi.DMI_AvmAddress_OutBUS, t_addr & 32'hFFFF_FFFC);
                chk("avm_byteenable", 32'(dmi.DMI_AvmByteenable_OutBUS), 32'(e_be));
                if (t_store) chk("avm_writedata", dmi.DMI_AvmWriteData_OutBUS, e_wd);
            end
            if (ed) begin
                chk("misaligned", 32'(dmi.DMI_Misaligned_Out), 32'(m));
                done_mis = dmi.DMI_Misaligned_Out;
                if (!m && !t_store) last_rd = t_rword >> (8 * t_addr[1:0]);
            end
            chk("readdata", dmi.DMI_ReadData_OutBUS, last_rd);
            if (t_active) cyc++;
        end
    end

    task automatic start_txn(input logic [31:0] addr, input logic st, input logic [3:0] be,
                             input logic [31:0] wd, input logic [31:0] rword, input int w,
                             input int d);
        @(posedge clk);
        #1;
        t_addr = addr; t_store = st; t_be = be; t_wd = wd; t_rword = rword;
        t_wait = w; t_delay = d;
        dmi.DMI_Address_InBUS    = addr;
        dmi.DMI_Store_In         = st;
        dmi.DMI_Byteenable_InBUS = be;
        dmi.DMI_WriteData_InBUS  = wd;
        dmi.DMI_Req_In           = 1'b1;
        t_active = 1'b1;
        txn_id++;
    endtask

    task automatic run_txn(input logic [31:0] addr, input logic st, input logic [3:0] be,
                           input logic [31:0] wd, input logic [31:0] rword, input int w,
                           input int d, input logic keep_req, output int lat);
        start_txn(addr, st, be, wd, rword, w, d);
        lat = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (dmi.DMI_Done_Out === 1'b1) begin
                lat = i;
                break;
            end
        end
        chk("txn_latency", 32'(lat), 32'(exp_lat(addr, st, be, w, d)));
        if (!keep_req) begin
            @(posedge clk);
            #1;
            dmi.DMI_Req_In = 1'b0;
            t_active = 1'b0;
        end
    endtask

    initial begin
        int lat;
        dmi.DMI_Req_In              = 1'b0;
        dmi.DMI_Store_In            = 1'b0;
        dmi.DMI_Address_InBUS       = 32'h0;
        dmi.DMI_WriteData_InBUS     = 32'h0;
        dmi.DMI_Byteenable_InBUS    = 4'h0;
        dmi.DMI_AvmReadData_InBUS   = 32'h0;
        dmi.DMI_AvmWaitrequest_In   = 1'b0;
        dmi.DMI_AvmReaddatavalid_In = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_read", 32'(dmi.DMI_AvmRead_Out), 32'h0);
        chk("rst_write", 32'(dmi.DMI_AvmWrite_Out), 32'h0);
        chk("rst_done", 32'(dmi.DMI_Done_Out), 32'h0);
        chk("rst_mis", 32'(dmi.DMI_Misaligned_Out), 32'h0);
        chk("rst_addr", dmi.DMI_AvmAddress_OutBUS, 32'h0);
        chk("rst_be", 32'(dmi.DMI_AvmByteenable_OutBUS), 32'h0);
        chk("rst_wd", dmi.DMI_AvmWriteData_OutBUS, 32'h0);
        chk("rst_rdata", dmi.DMI_ReadData_OutBUS, 32'h0);

        // word store with two waitrequest cycles
        run_txn(32'h100, 1'b1, FOUR_BYTES, 32'hDEADBEEF, 32'h0, 2, 0, 1'b0, lat);
        chk("lit_word_store_lat", 32'(lat), 32'd4);
        chk("lit_word_store_strobes", 32'(strb_cnt), 32'd3);
        chk("lit_word_store_addr", cap_addr, 32'h100);
        chk("lit_word_store_be", 32'(cap_be), 32'hF);
        chk("lit_word_store_wd", cap_wd, 32'hDEADBEEF);

        // byte store at offset 3
        run_txn(32'h203, 1'b1, ONE_BYTE, 32'h000000A5, 32'h0, 0, 0, 1'b0, lat);
        chk("lit_byte_store_lat", 32'(lat), 32'd2);
        chk("lit_byte_store_addr", cap_addr, 32'h200);
        chk("lit_byte_store_be", 32'(cap_be), 32'h8);
        chk("lit_byte_store_wd", cap_wd, 32'hA5000000);

        // halfword load at offset 2
        run_txn(32'h42, 1'b0, TWO_BYTES, 32'h0, 32'h12345678, 0, 1, 1'b0, lat);
        chk("lit_half_load_lat", 32'(lat), 32'd3);
        chk("lit_half_load_data", dmi.DMI_ReadData_OutBUS, 32'h00001234);
        chk("lit_half_load_strobes", 32'(strb_cnt), 32'd1);

        // misaligned word load
        run_txn(32'h41, 1'b0, FOUR_BYTES, 32'h0, 32'h99999999, 0, 1, 1'b0, lat);
        chk("lit_mis_lat", 32'(lat), 32'd1);
        chk("lit_mis_flag", 32'(done_mis), 32'h1);
        chk("lit_mis_strobes", 32'(strb_cnt), 32'd0);

        // same-cycle readdatavalid, then back-to-back byte load with Req held
        run_txn(32'h10, 1'b0, FOUR_BYTES, 32'h0, 32'hCAFEF00D, 1, 0, 1'b1, lat);
        chk("lit_same_cycle_lat", 32'(lat), 32'd3);
        chk("lit_same_cycle_data", dmi.DMI_ReadData_OutBUS, 32'hCAFEF00D);
        run_txn(32'h11, 1'b0, ONE_BYTE, 32'h0, 32'h11223344, 0, 2, 1'b0, lat);
        chk("lit_b2b_lat", 32'(lat), 32'd4);
        chk("lit_b2b_data", dmi.DMI_ReadData_OutBUS, 32'h00112233);

        // model-only patterns
        run_txn(32'h302, 1'b1, TWO_BYTES, 32'h0000BEEF, 32'h0, 1, 0, 1'b0, lat);
        chk("lit_half_store_wd", cap_wd, 32'hBEEF0000);
        run_txn(32'h301, 1'b1, TWO_BYTES, 32'h0000BEEF, 32'h0, 0, 0, 1'b0, lat);
        run_txn(32'h33, 1'b0, ONE_BYTE, 32'h0, 32'hAABBCCDD, 2, 3, 1'b0, lat);
        chk("lit_byte_load_top", dmi.DMI_ReadData_OutBUS, 32'h000000AA);
        run_txn(32'h12, 1'b1, ONE_BYTE, 32'h0000003C, 32'h0, 0, 0, 1'b0, lat);

        // reset while waiting in RESP; the late readdatavalid must be ignored
        start_txn(32'h80, 1'b0, FOUR_BYTES, 32'h0, 32'h55AA55AA, 0, 4);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        dmi.DMI_Req_In = 1'b0;
        t_active = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_read", 32'(dmi.DMI_AvmRead_Out), 32'h0);
        chk("rst_mid_done", 32'(dmi.DMI_Done_Out), 32'h0);
        chk("rst_mid_stall", 32'(dmi.DMI_Stall_Out), 32'h0);
        repeat (6) @(posedge clk);
        #1;
        chk("rst_late_rdv_ignored", dmi.DMI_ReadData_OutBUS, 32'h0);
        run_txn(32'h84, 1'b1, FOUR_BYTES, 32'h01020304, 32'h0, 0, 0, 1'b0, lat);
        chk("lit_after_reset_lat", 32'(lat), 32'd2);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
